// File: rtl/mdu_unit.sv
// mdu_unit: multicycle MIPS-style multiply/divide unit with HI/LO result registers.
// Latency: MULT_CYCLES (mult/multu/madd-class) or DIV_CYCLES (div/divu) busy cycles; mthi/mtlo write on the accepting edge.
// Backpressure: start is ignored while busy=1 or flush=1; the caller retries once busy=0 is seen.
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   start, mdu_op       request strobe and opcode (0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                       5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; others none)
//   A, B                operands, captured on the accepting edge
//   flush               aborts the in-flight operation, result discarded
//   busy                high while an operation is in flight
//   HI, LO              architectural result registers
//
// Build option: define MDU_MADD_EN to enable the multiply-accumulate ops 7-10;
// without it those opcodes behave as none.
//
// The result is computed from A/B (and the current HI/LO for accumulate ops) at
// acceptance and parked in a pending register; the busy counter only models the
// architectural latency. HI/LO cannot change while busy, so precomputing the
// accumulate result against them is safe.

module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       mdu_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);

  localparam logic [CW-1:0] MUL_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
  logic             pend_we_q, pend_we_d;
  logic [WIDTH-1:0] hi_d, lo_d;

  // ---------------- opcode decode ----------------
  logic op_mul, op_div, op_mac;

  assign op_mul = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
  assign op_div = (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
`ifdef MDU_MADD_EN
  assign op_mac = (mdu_op >= OP_MADD) && (mdu_op <= OP_MSUBU);
`else
  assign op_mac = 1'b0;
`endif

  // ---------------- multiply datapath ----------------
  // Extending both operands to 2*WIDTH and keeping the low 2*WIDTH bits of the
  // product gives the exact signed (or unsigned) full-width product.
  logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u, acc;

  assign a_sx   = {{WIDTH{A[WIDTH-1]}}, A};
  assign b_sx   = {{WIDTH{B[WIDTH-1]}}, B};
  assign a_zx   = {{WIDTH{1'b0}}, A};
  assign b_zx   = {{WIDTH{1'b0}}, B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;
  assign acc    = {HI, LO};

  // ---------------- divide datapath ----------------
  // Signed divide runs on magnitudes. The most negative dividend negates to
  // itself, which read as unsigned is the correct magnitude, so MIN / -1
  // yields quotient MIN and remainder 0 with no special case.
  // A zero divisor is swapped for 1 only to keep the divider defined; the
  // result is never written in that case.
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] abs_a, abs_b, sdiv_b, udiv_b;
  logic [WIDTH-1:0] sq, sr, quo_s, rem_s, quo_u, rem_u;

  assign a_neg  = A[WIDTH-1];
  assign b_neg  = B[WIDTH-1];
  assign b_zero = (B == '0);
  assign abs_a  = a_neg ? (~A + ONE) : A;
  assign abs_b  = b_neg ? (~B + ONE) : B;
  assign sdiv_b = b_zero ? ONE : abs_b;
  assign udiv_b = b_zero ? ONE : B;
  assign sq     = abs_a / sdiv_b;
  assign sr     = abs_a % sdiv_b;
  assign quo_s  = (a_neg ^ b_neg) ? (~sq + ONE) : sq;
  assign rem_s  = a_neg ? (~sr + ONE) : sr;
  assign quo_u  = A / udiv_b;
  assign rem_u  = A % udiv_b;

  // ---------------- result select ----------------
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             res_we;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    res_we = 1'b0;
    case (mdu_op)
      OP_MULT:  begin {res_hi, res_lo} = prod_s; res_we = 1'b1; end
      OP_MULTU: begin {res_hi, res_lo} = prod_u; res_we = 1'b1; end
      OP_DIV:   begin res_hi = rem_s; res_lo = quo_s; res_we = !b_zero; end
      OP_DIVU:  begin res_hi = rem_u; res_lo = quo_u; res_we = !b_zero; end
`ifdef MDU_MADD_EN
      OP_MADD:  begin {res_hi, res_lo} = acc + prod_s; res_we = 1'b1; end
      OP_MADDU: begin {res_hi, res_lo} = acc + prod_u; res_we = 1'b1; end
      OP_MSUB:  begin {res_hi, res_lo} = acc - prod_s; res_we = 1'b1; end
      OP_MSUBU: begin {res_hi, res_lo} = acc - prod_u; res_we = 1'b1; end
`endif
      default:  begin res_hi = '0; res_lo = '0; res_we = 1'b0; end
    endcase
  end

  // ---------------- control FSM: next state ----------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    hi_d      = HI;
    lo_d      = LO;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          if (op_mul || op_div || op_mac) begin
            state_d   = S_RUN;
            cnt_d     = op_div ? DIV_LOAD : MUL_LOAD;
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            pend_we_d = res_we;
          end else if (mdu_op == OP_MTHI) begin
            hi_d = A;
          end else if (mdu_op == OP_MTLO) begin
            lo_d = A;
          end
        end
      end
      S_RUN: begin
        if (flush) begin
          // Abort: drop the parked result, HI/LO untouched.
          state_d   = S_IDLE;
          cnt_d     = '0;
          pend_hi_d = '0;
          pend_lo_d = '0;
          pend_we_d = 1'b0;
        end else if (cnt_q == '0) begin
          // Last busy cycle: commit on the edge where busy falls.
          state_d   = S_IDLE;
          if (pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          pend_we_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
      HI        <= '0;
      LO        <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
      HI        <= hi_d;
      LO        <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed checks of mdu_unit at default parameters (WIDTH=32,
// MULT_CYCLES=5, DIV_CYCLES=10). Inputs are driven and outputs sampled 1ns
// after each rising edge.

module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] A, B;
  logic        flush;
  logic        busy;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;

  mdu_unit dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .mdu_op (mdu_op),
    .A      (A),
    .B      (B),
    .flush  (flush),
    .busy   (busy),
    .HI     (HI),
    .LO     (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one op, scramble A/B after acceptance, count busy cycles, and make
  // sure HI/LO do not move while busy. Returns after the edge busy falls on.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int ncyc);
    logic [31:0] h0, l0;
    int          n;
    bit          moved;
    h0 = HI;
    l0 = LO;
    mdu_op = op; A = a; B = b; start = 1'b1;
    tick;
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    n = 0;
    moved = 1'b0;
    while (busy && n < 100) begin
      n++;
      if (HI !== h0 || LO !== l0) moved = 1'b1;
      tick;
    end
    chk({tag, " cycles"}, 64'(n), 64'(ncyc));
    chk({tag, " hold"}, 64'(moved), 64'd0);
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] a);
    mdu_op = op; A = a; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    start   = 1'b0;
    mdu_op  = 4'd0;
    A       = '0;
    B       = '0;
    flush   = 1'b0;
    repeat (3) tick;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset HI", 64'(HI), 64'd0);
    chk("reset LO", 64'(LO), 64'd0);
    reset_n = 1'b1;
    tick;

    // multiply
    run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 5);
    chk("mult HI", 64'(HI), 64'hFFFF_FFFF);
    chk("mult LO", 64'(LO), 64'hFFFF_FFFA);
    run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 5);
    chk("multu HI", 64'(HI), 64'h0000_0002);
    chk("multu LO", 64'(LO), 64'hFFFF_FFFA);

    // divide
    run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10);
    chk("div LO", 64'(LO), 64'hFFFF_FFFD);
    chk("div HI", 64'(HI), 64'hFFFF_FFFF);
    run_op("divu", 4'd4, 32'd100, 32'd7, 10);
    chk("divu LO", 64'(LO), 64'd14);
    chk("divu HI", 64'(HI), 64'd2);
    run_op("div0", 4'd3, 32'd55, 32'd0, 10);
    chk("div0 LO", 64'(LO), 64'd14);
    chk("div0 HI", 64'(HI), 64'd2);
    run_op("divmin", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    chk("divmin LO", 64'(LO), 64'h8000_0000);
    chk("divmin HI", 64'(HI), 64'd0);
    run_op("divneg", 4'd3, 32'd7, 32'hFFFF_FFFE, 10);
    chk("divneg LO", 64'(LO), 64'hFFFF_FFFD);
    chk("divneg HI", 64'(HI), 64'd1);

    // flush at busy cycle 4, with a start in the flush cycle
    mdu_op = 4'd3; A = 32'd100; B = 32'd3; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (3) tick;
    chk("flush pre busy", 64'(busy), 64'd1);
    flush = 1'b1; mdu_op = 4'd1; A = 32'd9; B = 32'd9; start = 1'b1;
    tick;
    flush = 1'b0; start = 1'b0;
    chk("flush busy", 64'(busy), 64'd0);
    chk("flush HI", 64'(HI), 64'd1);
    chk("flush LO", 64'(LO), 64'hFFFF_FFFD);
    repeat (15) tick;
    chk("flush late busy", 64'(busy), 64'd0);
    chk("flush late HI", 64'(HI), 64'd1);
    chk("flush late LO", 64'(LO), 64'hFFFF_FFFD);

    // mtlo while busy is ignored; after busy falls it writes immediately
    mdu_op = 4'd1; A = 32'd2; B = 32'd3; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    mt(4'd6, 32'h1234_5678);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick;
    end
    chk("mtlo busy bound", 64'(busy), 64'd0);
    chk("mtlo ign HI", 64'(HI), 64'd0);
    chk("mtlo ign LO", 64'(LO), 64'd6);
    mt(4'd6, 32'h1234_5678);
    chk("mtlo LO", 64'(LO), 64'h1234_5678);
    chk("mtlo busy", 64'(busy), 64'd0);
    mt(4'd5, 32'hCAFE_0001);
    chk("mthi HI", 64'(HI), 64'hCAFE_0001);
    chk("mthi busy", 64'(busy), 64'd0);

    // none / unused opcodes
    mt(4'd0, 32'hDEAD_BEEF);
    chk("op0 busy", 64'(busy), 64'd0);
    mt(4'd15, 32'hDEAD_BEEF);
    chk("op15 busy", 64'(busy), 64'd0);
    chk("none HI", 64'(HI), 64'hCAFE_0001);
    chk("none LO", 64'(LO), 64'h1234_5678);

    // multiply-accumulate
    mt(4'd5, 32'd0);
    mt(4'd6, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    run_op("maddu", 4'd8, 32'd1, 32'd1, 5);
    chk("maddu HI", 64'(HI), 64'd1);
    chk("maddu LO", 64'(LO), 64'd0);
    run_op("madd", 4'd7, 32'hFFFF_FFFF, 32'd2, 5);
    chk("madd HI", 64'(HI), 64'd0);
    chk("madd LO", 64'(LO), 64'hFFFF_FFFE);
    run_op("msub", 4'd9, 32'd1, 32'd1, 5);
    chk("msub HI", 64'(HI), 64'd0);
    chk("msub LO", 64'(LO), 64'hFFFF_FFFD);
`else
    mdu_op = 4'd8; A = 32'd1; B = 32'd1; start = 1'b1;
    tick;
    start = 1'b0;
    chk("maddu off busy", 64'(busy), 64'd0);
    tick;
    chk("maddu off busy2", 64'(busy), 64'd0);
    chk("maddu off HI", 64'(HI), 64'd0);
    chk("maddu off LO", 64'(LO), 64'hFFFF_FFFF);
`endif

    // reset at busy cycle 2 of a mult
    mt(4'd5, 32'hA5A5_A5A5);
    mdu_op = 4'd1; A = 32'd5; B = 32'd5; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("rst pre busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst HI", 64'(HI), 64'd0);
    chk("rst LO", 64'(LO), 64'd0);
    repeat (2) tick;
    reset_n = 1'b1;
    repeat (12) tick;
    chk("rst late busy", 64'(busy), 64'd0);
    chk("rst late HI", 64'(HI), 64'd0);
    chk("rst late LO", 64'(LO), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
